// File: rtl/sobel_gradient_2.sv
// Streaming 3x3 Sobel engine: two line buffers feed a sliding window, and a
// registered output stage emits signed 11-bit gx/gy for every interior window.
module sobel_gradient_2 #(
   parameter int WIDTH  = 16,
   parameter int HEIGHT = 16
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        frame_start,
   input  logic        pixel_valid,
   input  logic [7:0]  pixel_in,
   output logic [10:0] gx_out_2,
   output logic [10:0] gy_out_2,
   output logic        grad_valid,
   output logic        frame_done
);

   // state  | meaning
   // IDLE   | after reset, waiting for frame_start, pixels ignored
   // ACTIVE | accepting pixels of the current frame
   // DONE   | last pixel accepted, pixels ignored until frame_start

   localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
   localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

   typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   col, col_eff, col_nxt;
   logic [RW-1:0]   row, row_eff, row_nxt;
   logic            accept, last_px;
   logic [7:0]      lb0 [WIDTH];
   logic [7:0]      lb1 [WIDTH];
   logic [7:0]      win [3][3];
   logic            win_ok, win_last;
   logic [10:0]     gx, gy;

   // frame_start with a valid pixel makes that pixel (0,0), so the counters
   // seen by this cycle's pixel are forced to zero.
   always_comb begin
      accept  = pixel_valid && (frame_start || state == ACTIVE);
      col_eff = frame_start ? '0 : col;
      row_eff = frame_start ? '0 : row;
      last_px = accept && (row_eff == RW'(HEIGHT-1)) && (col_eff == CW'(WIDTH-1));
   end

   always_comb begin
      state_nxt = state;
      col_nxt   = col;
      row_nxt   = row;
      if (frame_start) begin
         state_nxt = ACTIVE;
         col_nxt   = '0;
         row_nxt   = '0;
      end
      if (accept) begin
         if (last_px) begin
            state_nxt = DONE;
            col_nxt   = '0;
            row_nxt   = '0;
         end else if (col_eff == CW'(WIDTH-1)) begin
            col_nxt = '0;
            row_nxt = row_eff + RW'(1);
         end else begin
            col_nxt = col_eff + CW'(1);
            row_nxt = row_eff;
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state <= IDLE;
         col   <= '0;
         row   <= '0;
      end else begin
         state <= state_nxt;
         col   <= col_nxt;
         row   <= row_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         lb1[col_eff] <= lb0[col_eff];
         lb0[col_eff] <= pixel_in;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               win[r][c] <= '0;
         win_ok   <= 1'b0;
         win_last <= 1'b0;
      end else begin
         win_ok   <= accept && (row_eff >= RW'(2)) && (col_eff >= CW'(2));
         win_last <= last_px;
         if (accept) begin
            for (int r = 0; r < 3; r++) begin
               win[r][0] <= win[r][1];
               win[r][1] <= win[r][2];
            end
            win[0][2] <= lb1[col_eff];
            win[1][2] <= lb0[col_eff];
            win[2][2] <= pixel_in;
         end
      end
   end

   // Positive and negative halves each top out at 1020, so an 11-bit
   // wrap-around difference is the exact two's-complement result.
   always_comb begin
      gx = ({3'b0, win[0][2]} + {2'b0, win[1][2], 1'b0} + {3'b0, win[2][2]})
         - ({3'b0, win[0][0]} + {2'b0, win[1][0], 1'b0} + {3'b0, win[2][0]});
      gy = ({3'b0, win[2][0]} + {2'b0, win[2][1], 1'b0} + {3'b0, win[2][2]})
         - ({3'b0, win[0][0]} + {2'b0, win[0][1], 1'b0} + {3'b0, win[0][2]});
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         gx_out_2   <= '0;
         gy_out_2   <= '0;
         grad_valid <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         grad_valid <= win_ok;
         frame_done <= win_last;
         if (win_ok) begin
            gx_out_2 <= gx;
            gy_out_2 <= gy;
         end
      end
   end

endmodule

// File: tb/tb_sobel_gradient_2.sv
// Directed bench for sobel_gradient_2: known images with hand-derived
// gradients, pulse counts, latency, ignored pixels and async reset.
module tb_sobel_gradient_2;

   localparam int W    = 16;
   localparam int H    = 16;
   localparam int NWIN = (W-2)*(H-2);

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic        frame_start = 1'b0;
   logic        pixel_valid = 1'b0;
   logic [7:0]  pixel_in = '0;
   logic [10:0] gx_out_2, gy_out_2;
   logic        grad_valid, frame_done;

   int errors = 0, checks = 0;
   int cyc = 0, start_cyc = 0, k = 0, fd_cnt = 0, mode = 0;
   bit chk_first = 1'b0;
   logic [1:0] hist = '0;

   sobel_gradient_2 #(.WIDTH(W), .HEIGHT(H)) dut (
      .clk(clk), .n_rst(n_rst), .frame_start(frame_start),
      .pixel_valid(pixel_valid), .pixel_in(pixel_in),
      .gx_out_2(gx_out_2), .gy_out_2(gy_out_2),
      .grad_valid(grad_valid), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // 0 uniform, 1 vertical step, 2 falling col ramp, 3 row ramp, 4 col ramp
   function automatic int pix(input int m, input int r, input int c);
      case (m)
         0:       return 100;
         1:       return (c < 8) ? 0 : 255;
         2:       return 255 - 10*c;
         3:       return 10*r;
         default: return 10*c;
      endcase
   endfunction

   // c is the right-hand column of the window
   function automatic int exp_gx(input int m, input int c);
      case (m)
         1:       return (c == 8 || c == 9) ? 1020 : 0;
         2:       return -80;
         4:       return 80;
         default: return 0;
      endcase
   endfunction

   function automatic int exp_gy(input int m);
      return (m == 3) ? 80 : 0;
   endfunction

   always @(posedge clk) begin
      cyc  <= cyc + 1;
      hist <= {hist[0], pixel_valid};
   end

   always @(negedge clk) begin : mon
      int c;
      if (frame_done) fd_cnt++;
      if (grad_valid) begin
         c = 2 + k % (W-2);
         check("gx", int'(gx_out_2), exp_gx(mode, c) & 32'h7FF);
         check("gy", int'(gy_out_2), exp_gy(mode) & 32'h7FF);
         check("frame_done_flag", int'(frame_done), (k == NWIN-1) ? 1 : 0);
         check("latency_pixel", int'(hist[1]), 1);
         if (k == 0 && chk_first) check("first_latency", cyc - start_cyc, 36);
         k++;
      end
   end

   task automatic run_frame(input int m, input bit gaps, input int stop_row);
      int r, c, g;
      mode = m; k = 0; fd_cnt = 0; chk_first = !gaps;
      for (int idx = 0; idx < W*H; idx++) begin
         r = idx / W;
         c = idx % W;
         if (r == stop_row) break;
         @(negedge clk);
         frame_start = 1'b0;
         if (gaps && idx > 0) begin
            g = 0;
            while (g < 6 && $urandom_range(1, 0) == 1) begin
               pixel_valid = 1'b0;
               g++;
               @(negedge clk);
            end
         end
         frame_start = (idx == 0);
         if (idx == 0) start_cyc = cyc;
         pixel_valid = 1'b1;
         pixel_in    = 8'(pix(m, r, c));
      end
      @(negedge clk);
      frame_start = 1'b0;
      pixel_valid = 1'b0;
      if (stop_row >= H) begin
         repeat (4) @(negedge clk);
         check("pulse_count", k, NWIN);
         check("frame_done_count", fd_cnt, 1);
      end
   endtask

   task automatic stray_pixels(input string tag);
      k = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         pixel_valid = 1'b1;
         pixel_in    = 8'(20*i);
      end
      @(negedge clk);
      pixel_valid = 1'b0;
      repeat (4) @(negedge clk);
      check(tag, k, 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_gx", int'(gx_out_2), 0);
      check("rst_gy", int'(gy_out_2), 0);
      check("rst_valid", int'(grad_valid), 0);
      check("rst_done", int'(frame_done), 0);
      n_rst = 1'b1;

      stray_pixels("ignored_in_idle");
      run_frame(0, 1'b0, H);
      stray_pixels("ignored_after_done");
      run_frame(1, 1'b0, H);
      run_frame(2, 1'b0, H);
      run_frame(3, 1'b0, H);
      run_frame(4, 1'b1, H);

      run_frame(4, 1'b0, 5);
      #2;
      check("pre_reset_gx", int'(gx_out_2), 80);
      n_rst = 1'b0;
      #1;
      check("async_rst_gx", int'(gx_out_2), 0);
      check("async_rst_gy", int'(gy_out_2), 0);
      check("async_rst_valid", int'(grad_valid), 0);
      check("async_rst_done", int'(frame_done), 0);
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
      stray_pixels("ignored_after_reset");
      run_frame(1, 1'b0, H);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
